// File: rtl/bomb_controller.sv
// Single-bomb scheduler: grid-snapped placement, fuse timer, one-cycle detonation pulse, blast hold and pixel flags.
// Optional BOMB_REMOTE_DETONATE_EN: a second press during the fuse detonates the bomb early.
module bomb_controller #(
  parameter int unsigned FUSE_CYCLES  = 150_000_000,
  parameter int unsigned BLAST_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       C,
  input  logic       game_over,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] v_x,
  input  logic [9:0] v_y,
  output logic [9:0] e_x,
  output logic [9:0] e_y,
  output logic       explosion_SCEN,
  output logic       bomb_active,
  output logic       bomb_on,
  output logic       explosion_on
);

  localparam int unsigned CW = 28;
  localparam int unsigned PW = 10;
  localparam int unsigned AW = 11;

  localparam logic [AW-1:0] X_ORIGIN = 11'd143;
  localparam logic [AW-1:0] Y_ORIGIN = 11'd34;
  localparam logic [AW-1:0] SNAP_RND = 11'd8;
  localparam logic [AW-1:0] ALIGN    = 11'h7F0;

  localparam logic signed [AW-1:0] TILE_END  = 11'sd15;
  localparam logic signed [AW-1:0] BEAM_BACK = 11'sd48;
  localparam logic signed [AW-1:0] BEAM_FWD  = 11'sd63;

  localparam logic [CW-1:0] FUSE_LAST  = CW'(FUSE_CYCLES - 1);
  localparam logic [CW-1:0] BLAST_LAST = CW'(BLAST_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FUSE  = 2'd1,
    BLAST = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic          c_q;
  logic          press;
  logic          remote_fire;
  logic [9:0]    e_x_n, e_y_n;
  logic          scen_n;
  logic          active_n;

  // Round a sprite coordinate to the nearest tile origin on the 16-pixel playfield grid.
  function automatic logic [9:0] snap(input logic [9:0] p, input logic [AW-1:0] origin);
    logic [AW-1:0] off;
    off = ({1'b0, p} - origin + SNAP_RND) & ALIGN;
    return PW'(off + origin);
  endfunction

  assign press = C && !c_q;

`ifdef BOMB_REMOTE_DETONATE_EN
  assign remote_fire = press && (count != '0);
`else
  assign remote_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      c_q            <= 1'b0;
      e_x            <= '0;
      e_y            <= '0;
      explosion_SCEN <= 1'b0;
      bomb_active    <= 1'b0;
    end else begin
      state          <= state_n;
      count          <= count_n;
      c_q            <= C;
      e_x            <= e_x_n;
      e_y            <= e_y_n;
      explosion_SCEN <= scen_n;
      bomb_active    <= active_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    e_x_n   = e_x;
    e_y_n   = e_y;
    scen_n  = 1'b0;
    case (state)
      IDLE: begin
        if (press && !game_over) begin
          state_n = FUSE;
          count_n = '0;
          e_x_n   = snap(b_x, X_ORIGIN);
          e_y_n   = snap(b_y, Y_ORIGIN);
        end
      end
      FUSE: begin
        count_n = count + CW'(1);
        if (count == FUSE_LAST || remote_fire) begin
          state_n = BLAST;
          count_n = '0;
          scen_n  = 1'b1;
        end
      end
      BLAST: begin
        count_n = count + CW'(1);
        if (count == BLAST_LAST) begin
          state_n = IDLE;
          count_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
    active_n = (state_n != IDLE);
  end

  // Pixel windows are compared signed so beams left of / above the origin do not wrap.
  logic signed [AW-1:0] ex_s, ey_s, vx_s, vy_s;
  logic                 in_col, in_row, h_beam, v_beam;

  assign ex_s = signed'({1'b0, e_x});
  assign ey_s = signed'({1'b0, e_y});
  assign vx_s = signed'({1'b0, v_x});
  assign vy_s = signed'({1'b0, v_y});

  assign in_col = (vx_s >= ex_s) && (vx_s <= ex_s + TILE_END);
  assign in_row = (vy_s >= ey_s) && (vy_s <= ey_s + TILE_END);
  assign h_beam = in_row && (vx_s >= ex_s - BEAM_BACK) && (vx_s <= ex_s + BEAM_FWD);
  assign v_beam = in_col && (vy_s >= ey_s - BEAM_BACK) && (vy_s <= ey_s + BEAM_FWD);

  assign bomb_on      = (state == FUSE) && in_col && in_row;
  assign explosion_on = (state == BLAST) && (h_beam || v_beam);

endmodule

// File: tb/tb_bomb_controller.sv
// Bench for bomb_controller: directed scenarios plus randomized traffic against a timestamp-based reference model.
module tb_bomb_controller;

  localparam int F = 10;
  localparam int B = 5;
`ifdef BOMB_REMOTE_DETONATE_EN
  localparam bit REMOTE = 1'b1;
`else
  localparam bit REMOTE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       C = 1'b0;
  logic       game_over = 1'b0;
  logic [9:0] b_x = '0, b_y = '0, v_x = '0, v_y = '0;
  logic [9:0] e_x, e_y;
  logic       explosion_SCEN, bomb_active, bomb_on, explosion_on;

  bomb_controller #(.FUSE_CYCLES(F), .BLAST_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .C(C), .game_over(game_over),
    .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
    .e_x(e_x), .e_y(e_y), .explosion_SCEN(explosion_SCEN),
    .bomb_active(bomb_active), .bomb_on(bomb_on), .explosion_on(explosion_on)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: a bomb is described by its placement edge and its detonation edge.
  int n = 0;
  bit have = 0;
  int t_place = 0, t_det = 0;
  bit c_prev = 0;
  int mex = 0, mey = 0;

  function automatic bit m_fuse(int k);
    return have && k >= t_place && k < t_det;
  endfunction
  function automatic bit m_blast(int k);
    return have && k >= t_det && k < t_det + B;
  endfunction
  function automatic int snap(int p, int org);
    int off;
    off = ((p - org + 8) % 2048 + 2048) % 2048;
    return ((off / 16) * 16 + org) % 1024;
  endfunction
  function automatic bit in_rng(int x, int lo, int hi);
    return x >= lo && x <= hi;
  endfunction
  function automatic bit m_bomb_on(int vx, int vy);
    return m_fuse(n) && in_rng(vx, mex, mex + 15) && in_rng(vy, mey, mey + 15);
  endfunction
  function automatic bit m_expl_on(int vx, int vy);
    bit h, v;
    h = in_rng(vy, mey, mey + 15) && in_rng(vx, mex - 48, mex + 63);
    v = in_rng(vx, mex, mex + 15) && in_rng(vy, mey - 48, mey + 63);
    return m_blast(n) && (h || v);
  endfunction

  task automatic model_reset();
    have = 0; mex = 0; mey = 0; c_prev = 0;
  endtask

  task automatic model_edge();
    bit press;
    n++;
    if (reset) begin
      model_reset();
      return;
    end
    press = C && !c_prev;
    c_prev = C;
    if (!(m_fuse(n - 1) || m_blast(n - 1))) begin
      if (press && !game_over) begin
        have = 1; t_place = n; t_det = n + F;
        mex = snap(int'(b_x), 143);
        mey = snap(int'(b_y), 34);
      end
    end else if (m_fuse(n - 1) && REMOTE && press && (n - 1 - t_place) >= 1) begin
      t_det = n;
    end
  endtask

  task automatic check_all();
    check("bomb_active", bomb_active, m_fuse(n) || m_blast(n));
    check("explosion_SCEN", explosion_SCEN, have && n == t_det);
    check("e_x", e_x, mex);
    check("e_y", e_y, mey);
    check("bomb_on", bomb_on, m_bomb_on(int'(v_x), int'(v_y)));
    check("explosion_on", explosion_on, m_expl_on(int'(v_x), int'(v_y)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_scen(output int k);
    k = 0;
    do begin step(); k++; end while (explosion_SCEN !== 1'b1 && k < 60);
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    do begin step(); k++; end while (bomb_active !== 1'b0 && k < 60);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, k2, pulses, pulse, vx, vy;
    model_reset();
    repeat (3) step();
    reset = 1'b0;

    // Reset mid-fuse, then the reference placement at (150,45).
    b_x = 10'd200; b_y = 10'd100; C = 1'b1;
    step();
    C = 1'b0;
    repeat (4) step();
    #1 reset = 1'b1; model_reset();
    #1 check("rst_mid_active", bomb_active, 0);
    check("rst_mid_ex", e_x, 0);
    step();
    reset = 1'b0;
    step();
    b_x = 10'd150; b_y = 10'd45; C = 1'b1;
    step();
    C = 1'b0;
    check("place_active", bomb_active, 1);
    check("place_ex", e_x, 143);
    check("place_ey", e_y, 50);
    wait_scen(k);
    check("fuse_len", k, F);
    wait_idle(k2);
    check("active_len", k + k2, F + B);

    // C held high: one bomb, one pulse.
    step();
    C = 1'b1; pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (explosion_SCEN) pulses++;
    end
    check("held_pulses", pulses, 1);
    C = 1'b0;
    repeat (2) step();

    // Second press three cycles after placement.
    b_x = 10'd300; b_y = 10'd200; C = 1'b1;
    step();
    C = 1'b0; pulse = -1;
    for (int i = 1; i <= 40 && pulse < 0; i++) begin
      C = (i == 3);
      if (i == 3) begin b_x = 10'd500; b_y = 10'd400; end
      step();
      if (explosion_SCEN) begin
        pulse = i;
        check("remote_ex", e_x, 303);
        check("remote_ey", e_y, 194);
      end
    end
    C = 1'b0;
    check("remote_pulse", pulse, REMOTE ? 3 : F);
    wait_idle(k);
    step();

    // game_over blocks placement in IDLE but does not cancel a running fuse.
    game_over = 1'b1; C = 1'b1;
    step();
    check("go_block", bomb_active, 0);
    C = 1'b0; game_over = 1'b0;
    step();
    C = 1'b1;
    step();
    C = 1'b0; pulse = -1;
    for (int i = 1; i <= 40 && pulse < 0; i++) begin
      game_over = (i >= 4);
      step();
      if (explosion_SCEN) pulse = i;
    end
    check("go_pulse", pulse, F);
    wait_idle(k);
    game_over = 1'b0;
    step();

    // Pixel flags around the tile at (143,34).
    b_x = 10'd143; b_y = 10'd34; C = 1'b1;
    step();
    C = 1'b0;
    v_x = 10'd150; v_y = 10'd40;
    #1 check("bomb_in", bomb_on, 1);
    v_x = 10'd159;
    #1 check("bomb_edge", bomb_on, 0);
    wait_scen(k);
    v_x = 10'd100; v_y = 10'd40;
    #1 check("xp_h_in", explosion_on, 1);
    v_y = 10'd60;
    #1 check("xp_off", explosion_on, 0);
    v_x = 10'd150; v_y = 10'd97;
    #1 check("xp_v_end", explosion_on, 1);
    v_y = 10'd98;
    #1 check("xp_v_past", explosion_on, 0);
    wait_idle(k);
    step();

    // Reset on the detonation cycle.
    C = 1'b1;
    step();
    C = 1'b0;
    wait_scen(k);
    #1 reset = 1'b1; model_reset();
    #1 check("rst_scen", explosion_SCEN, 0);
    check("rst_active", bomb_active, 0);
    step();
    reset = 1'b0; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (explosion_SCEN) pulses++;
    end
    check("rst_no_pulse", pulses, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) C = ~C;
      if ($urandom_range(0, 19) == 0) game_over = ~game_over;
      b_x = 10'($urandom_range(143, 700));
      b_y = 10'($urandom_range(34, 450));
      vx = mex - 60 + int'($urandom_range(0, 140));
      vy = mey - 60 + int'($urandom_range(0, 140));
      v_x = 10'((vx < 0) ? 0 : vx);
      v_y = 10'((vy < 0) ? 0 : vy);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        model_reset();
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bomb_controller.md
# bomb_controller

Single-bomb scheduler that sits between the player inputs and the bomberman/explosion datapath. On a rising edge of the centre button it places a bomb snapped to the 16-pixel tile grid under the bomberman sprite, runs a fuse timer, and then issues the one-cycle explosion pulse and explosion coordinates consumed by the bomberman module. It also holds the blast on screen for a fixed time and drives the per-pixel `bomb_on` / `explosion_on` flags for the top module's colour mux.

## Interface

Parameters:
- `FUSE_CYCLES`, default 150_000_000: clock cycles from placement to detonation (1.5 s at 100 MHz); must be ≥2 and <2^28.
- `BLAST_CYCLES`, default 50_000_000: cycles the blast stays active; must be ≥1 and <2^28.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: async active-high reset.
- `C` in 1: centre button, level; bomb request on rising edge.
- `game_over` in 1: from bomberman; blocks new placements.
- `b_x`, `b_y` in 10: bomberman sprite top-left pixel.
- `v_x`, `v_y` in 10: current VGA pixel.
- `e_x`, `e_y` out 10: bomb/explosion tile top-left; reset 0.
- `explosion_SCEN` out 1: one-cycle detonation pulse; reset 0.
- `bomb_active` out 1: high in FUSE or BLAST; reset 0.
- `bomb_on` out 1: current pixel inside the bomb tile during FUSE; combinational.
- `explosion_on` out 1: current pixel inside the blast plus-shape during BLAST; combinational.

## Operation

- State machine: IDLE, FUSE, BLAST; reset → IDLE. The 28-bit `count` resets to 0, `C_q` to 0.
- `C_q` registers `C` each cycle. A press is `C && !C_q`.
- IDLE → FUSE on a press with `!game_over`. Same edge:
  - `e_x <= 143 + ((b_x - 143 + 8) >> 4 << 4)` and `e_y <= 34 + ((b_y - 34 + 8) >> 4 << 4)`.
  - Arithmetic is 11-bit unsigned, truncated to 10 bits.
  - `count <= 0`.
- FUSE:
  - `count` increments each cycle.
  - When `count == FUSE_CYCLES-1`: go to BLAST, `count <= 0`, `explosion_SCEN <= 1`.
- BLAST:
  - `explosion_SCEN` is high for the first BLAST cycle only.
  - `count` increments each cycle.
  - When `count == BLAST_CYCLES-1`: go to IDLE.
- `e_x` / `e_y` hold from placement until the next placement.
- Presses in FUSE or BLAST are ignored and not queued. Exception: remote detonation, see Configuration.
- `game_over` rising mid-FUSE does not cancel the bomb; the fuse and blast complete normally.
- `bomb_on` = state==FUSE && `e_x ≤ v_x ≤ e_x+15` && `e_y ≤ v_y ≤ e_y+15`.
- `explosion_on` = state==BLAST && one of:
  - horizontal beam: `e_y ≤ v_y ≤ e_y+15` and `e_x-48 ≤ v_x ≤ e_x+63`.
  - vertical beam: `e_x ≤ v_x ≤ e_x+15` and `e_y-48 ≤ v_y ≤ e_y+63`.
  - Compare in 11-bit signed, so `e_x-48` below 0 does not wrap.
- Reset mid-operation: immediate return to IDLE; all registered outputs go to 0 and any pending detonation is lost.

## Timing

- Placement latency: `bomb_active` rises on the edge sampling the first `C`=1 after a 0.
- `explosion_SCEN` is high exactly `FUSE_CYCLES` cycles after `bomb_active` rises, for exactly 1 cycle.
- `bomb_active` stays high for `FUSE_CYCLES + BLAST_CYCLES` cycles total.
- A new placement is possible on the first IDLE cycle after BLAST.
- `e_x` / `e_y` are stable in the cycle `explosion_SCEN` is high.
- `bomb_on` and `explosion_on` are purely combinational from state, `e_*` and `v_*`, with no added latency.

## Configuration

- `BOMB_REMOTE_DETONATE_EN` defined: a press in FUSE with `count ≥ 1` goes to BLAST on that edge, with `count <= 0` and `explosion_SCEN <= 1`, exactly as a natural fuse expiry.
- `BOMB_REMOTE_DETONATE_EN` undefined: presses in FUSE are ignored and the fuse always runs to `FUSE_CYCLES`.

## Test plan

Run with `FUSE_CYCLES`=10 and `BLAST_CYCLES`=5.

1. Reset asserted mid-run → all outputs 0 and state IDLE. Then `b_x`=150, `b_y`=45, `C` 0→1 → `bomb_active` high next edge, `e_x`=143, `e_y`=50, `explosion_SCEN` pulses exactly 10 cycles later, `bomb_active` falls 15 cycles after rising.
2. `C` held high continuously for 40 cycles → exactly one bomb and one `explosion_SCEN` pulse.
3. Second `C` edge 3 cycles after placement → without the macro, pulse still at cycle 10; with `BOMB_REMOTE_DETONATE_EN`, pulse on that edge and `e_x`/`e_y` unchanged.
4. `game_over`=1 in IDLE with a `C` edge → no placement. `game_over` rising at fuse cycle 4 → pulse still at cycle 10.
5. During BLAST with `e_x`=143, `e_y`=34: `v_x`=100, `v_y`=40 → `explosion_on`=1; `v_x`=100, `v_y`=60 → 0; `v_x`=150, `v_y`=97 → 1; `v_x`=150, `v_y`=98 → 0.
6. Reset asserted on the explosion cycle → `explosion_SCEN` and `bomb_active` drop immediately, and no pulse follows after reset release.
